ysyx_210544_wb_stage: RTL and testbench
=======================================

YSYX_210544_WB_STAGE -- requirements
Module: ysyx_210544_wb_stage

Interface
REQ-001 Parameter WDOG_LIMIT, default 1024, meaning cycles a commit request may wait unacknowledged before timeout is flagged.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_wb_memoryed_req  in  1  upstream (memory stage) entry valid.
REQ-005 o_wb_memoryed_ack  out  1  upstream entry accepted this cycle when high together with req.
REQ-006 i_wb_pc / i_wb_inst / i_wb_rd / i_wb_rd_wen / i_wb_rd_wdata / i_wb_skipcmt / i_wb_intrNo  in  64/32/5/1/64/1/32  retired-instruction payload.
REQ-007 o_rf_wen / o_rf_waddr / o_rf_wdata  out  1/5/64  register-file write port.
REQ-008 o_cmt_writebacked_req  out  1  commit request to commit stage.
REQ-009 i_cmt_writebacked_ack  in  1  commit stage acknowledge.
REQ-010 o_cmt_pc / o_cmt_inst / o_cmt_rd / o_cmt_rd_wen / o_cmt_rd_wdata / o_cmt_skipcmt / o_cmt_intrNo  out  64/32/5/1/64/1/32  held payload.
REQ-011 o_instret  out  64  count of committed entries.
REQ-012 o_halted  out  1  trap instruction (32'h6b) accepted; stage frozen.
REQ-013 o_wdog_timeout  out  1  sticky watchdog flag.

Function
REQ-014 Single-entry holding register; states EMPTY, FULL, HALT.
REQ-015 Commit handshake ("cmt_hs") = o_cmt_writebacked_req & i_cmt_writebacked_ack; upstream handshake ("up_hs") = i_wb_memoryed_req & o_wb_memoryed_ack.
REQ-016 o_wb_memoryed_ack = (state==EMPTY) | (state==FULL & i_cmt_writebacked_ack); 0 in HALT; combinational.
REQ-017 o_cmt_writebacked_req = 1 exactly when state is FULL; payload outputs drive the held register and are stable while req is high without ack.
REQ-018 On up_hs, payload latched at the edge; req rises the next cycle (latency 1).
REQ-019 o_rf_wen = up_hs & i_wb_rd_wen & (i_wb_rd != 0), combinational; waddr/wdata pass i_wb_rd/i_wb_rd_wdata; x0 never written.
REQ-020 Register file therefore reflects an entry's write in the first cycle its req is high.
REQ-021 Transitions: EMPTY->FULL on up_hs; FULL->EMPTY on cmt_hs without up_hs; FULL->FULL on cmt_hs with up_hs (back-to-back, no bubble); FULL holds without cmt_hs.
REQ-022 If the accepted inst equals 32'h6b, state goes to FULL then, on its cmt_hs, to HALT; o_halted=1 from that cmt_hs edge; no further up_hs in HALT.
REQ-023 Simultaneous cmt_hs of the trap entry and new upstream req: req is not accepted (ack gated when held inst==32'h6b).
REQ-024 o_instret increments by 1 on every cmt_hs, including skipcmt entries; wraps modulo 2^64.
REQ-025 Watchdog counter clears on cmt_hs or when not FULL, increments while FULL without ack, saturates; o_wdog_timeout sets when counter reaches WDOG_LIMIT, cleared only by reset.

Reset
REQ-026 On rst: state EMPTY, req 0, held payload 0, o_instret 0, o_halted 0, watchdog 0, o_wdog_timeout 0.
REQ-027 rst asserted mid-operation discards held entry without a commit; o_rf_wen forced 0 while rst high.

Structure
REQ-028 State encodings and the trap opcode 32'h6b go in the shared defines file; bus widths use existing `BUS_64/`BUS_32.
REQ-029 One natural sub-module: ysyx_210544_wb_wdog (watchdog counter + sticky flag).

Verification
REQ-030 Single entry pc=0x80000000, rd=5, wdata=0x1234, ack held 1 -> rf write x5=0x1234 in accept cycle, req high one cycle later, instret=1.
REQ-031 Ack held 0 for 10 cycles after req -> payload stable, o_wb_memoryed_ack=0, instret unchanged; ack then -> instret increments once.
REQ-032 Continuous upstream valid, ack=1 -> one commit per cycle, no bubbles, 8 entries -> instret=8.
REQ-033 rd=0, rd_wen=1 -> o_rf_wen=0; commit still occurs with rd_wen=1 reported.
REQ-034 Trap 32'h6b followed by valid entry -> trap commits, o_halted=1, later entry never acked.
REQ-035 WDOG_LIMIT=16, ack held 0 -> o_wdog_timeout rises after 16 FULL cycles, stays set after ack; rst mid-hold -> req drops next cycle, instret 0.

Source files
------------

// File: rtl/ysyx_210544_wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus widths, state encoding,
// trap opcode and the held-entry layout.
package ysyx_210544_wb_stage_pkg;

  localparam int BUS_64 = 64;
  localparam int BUS_32 = 32;
  localparam int RF_AW  = 5;

  localparam logic [BUS_32-1:0] TRAP_INST = 32'h0000_006b;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_FULL  = 2'd1,
    WB_HALT  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [BUS_64-1:0] pc;
    logic [BUS_32-1:0] inst;
    logic [RF_AW-1:0]  rd;
    logic              rd_wen;
    logic [BUS_64-1:0] rd_wdata;
    logic              skipcmt;
    logic [BUS_32-1:0] intr_no;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_210544_wb_wdog.sv
// Commit watchdog: counts cycles an entry waits unacknowledged and raises a
// sticky timeout flag once the count reaches WDOG_LIMIT.
module ysyx_210544_wb_wdog #(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic full_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int              CNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!full_i || ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == LIMIT) begin
      timeout_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs; the reset is synchronous, so only clk is listed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/ysyx_210544_wb_stage.sv
// Write-back stage: single-entry holding register between memory and commit,
// with register-file write on accept, retire counter and trap halt.
module ysyx_210544_wb_stage
  import ysyx_210544_wb_stage_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_wb_memoryed_req,
  output logic              o_wb_memoryed_ack,
  input  logic [BUS_64-1:0] i_wb_pc,
  input  logic [BUS_32-1:0] i_wb_inst,
  input  logic [RF_AW-1:0]  i_wb_rd,
  input  logic              i_wb_rd_wen,
  input  logic [BUS_64-1:0] i_wb_rd_wdata,
  input  logic              i_wb_skipcmt,
  input  logic [BUS_32-1:0] i_wb_intrNo,

  output logic              o_rf_wen,
  output logic [RF_AW-1:0]  o_rf_waddr,
  output logic [BUS_64-1:0] o_rf_wdata,

  output logic              o_cmt_writebacked_req,
  input  logic              i_cmt_writebacked_ack,
  output logic [BUS_64-1:0] o_cmt_pc,
  output logic [BUS_32-1:0] o_cmt_inst,
  output logic [RF_AW-1:0]  o_cmt_rd,
  output logic              o_cmt_rd_wen,
  output logic [BUS_64-1:0] o_cmt_rd_wdata,
  output logic              o_cmt_skipcmt,
  output logic [BUS_32-1:0] o_cmt_intrNo,

  output logic [BUS_64-1:0] o_instret,
  output logic              o_halted,
  output logic              o_wdog_timeout
);

  wb_state_e         state_q, state_d;
  wb_entry_t         entry_q, entry_d;
  logic [BUS_64-1:0] instret_q, instret_d;

  logic full, trap_held, up_ack, up_hs, cmt_hs;

  assign full      = (state_q == WB_FULL);
  assign trap_held = (entry_q.inst == TRAP_INST);
  assign cmt_hs    = full & i_cmt_writebacked_ack;
  // A held trap must not admit a successor, even as it commits.
  assign up_ack    = !rst & ((state_q == WB_EMPTY) |
                             (full & i_cmt_writebacked_ack & !trap_held));
  assign up_hs     = i_wb_memoryed_req & up_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_EMPTY: if (up_hs) state_d = WB_FULL;
      WB_FULL: begin
        if (cmt_hs) begin
          if (trap_held)  state_d = WB_HALT;
          else if (up_hs) state_d = WB_FULL;
          else            state_d = WB_EMPTY;
        end
      end
      WB_HALT:  state_d = WB_HALT;
      default:  state_d = WB_EMPTY;
    endcase
  end

  always_comb begin
    entry_d   = entry_q;
    instret_d = instret_q + BUS_64'(cmt_hs);
    if (up_hs) begin
      entry_d = '{pc:       i_wb_pc,
                  inst:     i_wb_inst,
                  rd:       i_wb_rd,
                  rd_wen:   i_wb_rd_wen,
                  rd_wdata: i_wb_rd_wdata,
                  skipcmt:  i_wb_skipcmt,
                  intr_no:  i_wb_intrNo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WB_EMPTY;
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  ysyx_210544_wb_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .full_i    (full),
    .ack_i     (i_cmt_writebacked_ack),
    .timeout_o (o_wdog_timeout)
  );

  // The register file is written as the entry is accepted, so it is current
  // by the first cycle that entry's commit request is visible.
  assign o_rf_wen   = up_hs & i_wb_rd_wen & (i_wb_rd != '0);
  assign o_rf_waddr = i_wb_rd;
  assign o_rf_wdata = i_wb_rd_wdata;

  assign o_wb_memoryed_ack     = up_ack;
  assign o_cmt_writebacked_req = full;
  assign o_cmt_pc              = entry_q.pc;
  assign o_cmt_inst            = entry_q.inst;
  assign o_cmt_rd              = entry_q.rd;
  assign o_cmt_rd_wen          = entry_q.rd_wen;
  assign o_cmt_rd_wdata        = entry_q.rd_wdata;
  assign o_cmt_skipcmt         = entry_q.skipcmt;
  assign o_cmt_intrNo          = entry_q.intr_no;

  assign o_instret = instret_q;
  assign o_halted  = (state_q == WB_HALT);

endmodule

// File: tb/tb_ysyx_210544_wb_stage.sv
// Self-checking bench for ysyx_210544_wb_stage: table-driven stream plus
// directed sequences, with a commit scoreboard fed on every upstream accept.
module tb_ysyx_210544_wb_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] wdata;
    logic        skip;
    logic [31:0] intr;
  } ent_t;

  typedef struct {
    ent_t p;
    logic exp_rf_wen;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wb_memoryed_req;
  logic        o_wb_memoryed_ack;
  logic [63:0] i_wb_pc;
  logic [31:0] i_wb_inst;
  logic [4:0]  i_wb_rd;
  logic        i_wb_rd_wen;
  logic [63:0] i_wb_rd_wdata;
  logic        i_wb_skipcmt;
  logic [31:0] i_wb_intrNo;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
  logic        o_cmt_writebacked_req;
  logic        i_cmt_writebacked_ack;
  logic [63:0] o_cmt_pc;
  logic [31:0] o_cmt_inst;
  logic [4:0]  o_cmt_rd;
  logic        o_cmt_rd_wen;
  logic [63:0] o_cmt_rd_wdata;
  logic        o_cmt_skipcmt;
  logic [31:0] o_cmt_intrNo;
  logic [63:0] o_instret;
  logic        o_halted;
  logic        o_wdog_timeout;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  ysyx_210544_wb_stage #(.WDOG_LIMIT(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_wb_memoryed_req     (i_wb_memoryed_req),
    .o_wb_memoryed_ack     (o_wb_memoryed_ack),
    .i_wb_pc               (i_wb_pc),
    .i_wb_inst             (i_wb_inst),
    .i_wb_rd               (i_wb_rd),
    .i_wb_rd_wen           (i_wb_rd_wen),
    .i_wb_rd_wdata         (i_wb_rd_wdata),
    .i_wb_skipcmt          (i_wb_skipcmt),
    .i_wb_intrNo           (i_wb_intrNo),
    .o_rf_wen              (o_rf_wen),
    .o_rf_waddr            (o_rf_waddr),
    .o_rf_wdata            (o_rf_wdata),
    .o_cmt_writebacked_req (o_cmt_writebacked_req),
    .i_cmt_writebacked_ack (i_cmt_writebacked_ack),
    .o_cmt_pc              (o_cmt_pc),
    .o_cmt_inst            (o_cmt_inst),
    .o_cmt_rd              (o_cmt_rd),
    .o_cmt_rd_wen          (o_cmt_rd_wen),
    .o_cmt_rd_wdata        (o_cmt_rd_wdata),
    .o_cmt_skipcmt         (o_cmt_skipcmt),
    .o_cmt_intrNo          (o_cmt_intrNo),
    .o_instret             (o_instret),
    .o_halted              (o_halted),
    .o_wdog_timeout        (o_wdog_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] inst,
                              input logic [4:0] rd, input logic wen,
                              input logic [63:0] wdata, input logic skip,
                              input logic [31:0] intr);
    ent_t e;
    e.pc = pc; e.inst = inst; e.rd = rd; e.rd_wen = wen;
    e.wdata = wdata; e.skip = skip; e.intr = intr;
    return e;
  endfunction

  task automatic set_in(input ent_t e);
    i_wb_memoryed_req = 1'b1;
    i_wb_pc       = e.pc;
    i_wb_inst     = e.inst;
    i_wb_rd       = e.rd;
    i_wb_rd_wen   = e.rd_wen;
    i_wb_rd_wdata = e.wdata;
    i_wb_skipcmt  = e.skip;
    i_wb_intrNo   = e.intr;
  endtask

  task automatic idle();
    i_wb_memoryed_req = 1'b0;
    i_wb_rd_wen       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an entry, sample at the falling edge and record it if accepted.
  task automatic offer(input ent_t e);
    set_in(e);
    @(negedge clk);
    if (o_wb_memoryed_ack) sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    @(negedge clk);
    check("rst_req",     o_cmt_writebacked_req, 1'b0);
    check("rst_instret", o_instret,             64'd0);
    check("rst_halted",  o_halted,              1'b0);
    check("rst_timeout", o_wdog_timeout,        1'b0);
    check("rst_pc",      o_cmt_pc,              64'd0);
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    ent_t a, e;
    if (!rst && o_cmt_writebacked_req && i_cmt_writebacked_ack) begin
      a = mk(o_cmt_pc, o_cmt_inst, o_cmt_rd, o_cmt_rd_wen, o_cmt_rd_wdata,
             o_cmt_skipcmt, o_cmt_intrNo);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmt_unexpected actual_pc=%h expected=no_commit", a.pc);
      end else begin
        e = sb.pop_front();
        check("cmt_pc",    a.pc,    e.pc);
        check("cmt_inst",  64'(a.inst), 64'(e.inst));
        check("cmt_wdata", a.wdata, e.wdata);
        check("cmt_misc",  64'({a.rd, a.rd_wen, a.skip, a.intr}),
                           64'({e.rd, e.rd_wen, e.skip, e.intr}));
      end
    end
  end

  vec_t vecs[8];
  ent_t e, a_ent, b_ent;

  initial begin
    vecs[0].p = mk(64'h8000_0100, 32'h0000_0013, 5'd1,  1'b1, 64'h1111, 1'b0, 32'd0); vecs[0].exp_rf_wen = 1'b1;
    vecs[1].p = mk(64'h8000_0104, 32'h0000_0033, 5'd0,  1'b1, 64'hdead, 1'b0, 32'd0); vecs[1].exp_rf_wen = 1'b0;
    vecs[2].p = mk(64'h8000_0108, 32'h0000_0023, 5'd9,  1'b0, 64'h2222, 1'b0, 32'd0); vecs[2].exp_rf_wen = 1'b0;
    vecs[3].p = mk(64'h8000_010c, 32'h0000_0013, 5'd31, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b0, 32'd0); vecs[3].exp_rf_wen = 1'b1;
    vecs[4].p = mk(64'h8000_0110, 32'h0000_0073, 5'd2,  1'b1, 64'h3333, 1'b1, 32'd0); vecs[4].exp_rf_wen = 1'b1;
    vecs[5].p = mk(64'h8000_0114, 32'h0000_0013, 5'd0,  1'b0, 64'h4444, 1'b0, 32'd7); vecs[5].exp_rf_wen = 1'b0;
    vecs[6].p = mk(64'h8000_0118, 32'h0000_0013, 5'd17, 1'b1, 64'h5555, 1'b0, 32'd0); vecs[6].exp_rf_wen = 1'b1;
    vecs[7].p = mk(64'h8000_011c, 32'h0000_0013, 5'd4,  1'b1, 64'h6666, 1'b0, 32'd0); vecs[7].exp_rf_wen = 1'b1;

    i_cmt_writebacked_ack = 1'b0;
    set_in(mk(64'd0, 32'd0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0));
    do_reset();
    @(negedge clk);
    check("ack_empty", o_wb_memoryed_ack, 1'b1);

    // Single entry, commit ack held high.
    step();
    i_cmt_writebacked_ack = 1'b1;
    offer(mk(64'h8000_0000, 32'h0000_0013, 5'd5, 1'b1, 64'h1234, 1'b0, 32'd0));
    check("single_rf_wen",   o_rf_wen,   1'b1);
    check("single_rf_waddr", o_rf_waddr, 5'd5);
    check("single_rf_wdata", o_rf_wdata, 64'h1234);
    check("single_req_lat0", o_cmt_writebacked_req, 1'b0);
    step();
    idle();
    @(negedge clk);
    check("single_req_lat1", o_cmt_writebacked_req, 1'b1);
    step();
    @(negedge clk);
    check("single_req_drop", o_cmt_writebacked_req, 1'b0);
    check("single_instret",  o_instret, 64'd1);

    // Commit stalled for 10 cycles with a follower waiting upstream.
    step();
    i_cmt_writebacked_ack = 1'b0;
    a_ent = mk(64'h8000_0040, 32'h0000_0013, 5'd6, 1'b1, 64'haaaa, 1'b0, 32'd0);
    b_ent = mk(64'h8000_0044, 32'h0000_0013, 5'd7, 1'b1, 64'hbbbb, 1'b0, 32'd0);
    offer(a_ent);
    step();
    set_in(b_ent);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_up_ack",  o_wb_memoryed_ack,     1'b0);
      check("stall_req",     o_cmt_writebacked_req, 1'b1);
      check("stall_pc",      o_cmt_pc,              a_ent.pc);
      check("stall_wdata",   o_cmt_rd_wdata,        a_ent.wdata);
      check("stall_instret", o_instret,             64'd1);
      check("stall_rf_wen",  o_rf_wen,              1'b0);
      step();
    end
    i_cmt_writebacked_ack = 1'b1;
    @(negedge clk);
    check("release_up_ack", o_wb_memoryed_ack, 1'b1);
    check("release_rf_wen", o_rf_wen,          1'b1);
    sb.push_back(b_ent);
    step();
    idle();
    @(negedge clk);
    check("release_instret", o_instret,             64'd2);
    check("release_req_b",   o_cmt_writebacked_req, 1'b1);
    step();
    @(negedge clk);
    check("release_instret2", o_instret,             64'd3);
    check("release_req_drop", o_cmt_writebacked_req, 1'b0);

    // Back-to-back stream from the vector table, commit ack held high.
    step();
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].p);
      @(negedge clk);
      check("stream_up_ack", o_wb_memoryed_ack, 1'b1);
      check("stream_rf_wen", o_rf_wen,          vecs[i].exp_rf_wen);
      if (vecs[i].exp_rf_wen) begin
        check("stream_rf_waddr", o_rf_waddr, vecs[i].p.rd);
        check("stream_rf_wdata", o_rf_wdata, vecs[i].p.wdata);
      end
      if (i > 0) check("stream_no_bubble", o_cmt_writebacked_req, 1'b1);
      sb.push_back(vecs[i].p);
      step();
    end
    idle();
    @(negedge clk);
    check("stream_last_req", o_cmt_writebacked_req, 1'b1);
    step();
    @(negedge clk);
    check("stream_drained", o_cmt_writebacked_req, 1'b0);
    check("stream_instret", o_instret,             64'd11);
    check("stream_sb_empty", 64'(sb.size()),       64'd0);

    // Trap followed by a valid entry.
    do_reset();
    i_cmt_writebacked_ack = 1'b1;
    offer(mk(64'h8000_0200, 32'h0000_006b, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0));
    check("trap_accept", o_wb_memoryed_ack, 1'b1);
    step();
    e = mk(64'h8000_0204, 32'h0000_0013, 5'd3, 1'b1, 64'hcccc, 1'b0, 32'd0);
    set_in(e);
    @(negedge clk);
    check("trap_gate_ack", o_wb_memoryed_ack,     1'b0);
    check("trap_gate_rf",  o_rf_wen,              1'b0);
    check("trap_req",      o_cmt_writebacked_req, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_flag",    o_halted,              1'b1);
      check("halt_up_ack",  o_wb_memoryed_ack,     1'b0);
      check("halt_req",     o_cmt_writebacked_req, 1'b0);
      check("halt_instret", o_instret,             64'd1);
      step();
    end

    // Watchdog with limit 16, then reset during a held entry.
    do_reset();
    i_cmt_writebacked_ack = 1'b0;
    offer(mk(64'h8000_0300, 32'h0000_0013, 5'd8, 1'b1, 64'h7777, 1'b0, 32'd0));
    step();
    idle();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("wdog_flag", o_wdog_timeout, (k == 17) ? 1'b1 : 1'b0);
      step();
    end
    i_cmt_writebacked_ack = 1'b1;
    @(negedge clk);
    step();
    i_cmt_writebacked_ack = 1'b0;
    @(negedge clk);
    check("wdog_sticky",  o_wdog_timeout, 1'b1);
    check("wdog_instret", o_instret,      64'd1);

    offer(mk(64'h8000_0400, 32'h0000_0013, 5'd10, 1'b1, 64'h8888, 1'b0, 32'd0));
    step();
    idle();
    @(negedge clk);
    check("midrst_held", o_cmt_writebacked_req, 1'b1);
    step();
    rst = 1'b1;
    set_in(mk(64'h8000_0404, 32'h0000_0013, 5'd7, 1'b1, 64'h9999, 1'b0, 32'd0));
    @(negedge clk);
    check("midrst_rf_wen", o_rf_wen, 1'b0);
    step();
    rst = 1'b0;
    idle();
    sb.delete();
    @(negedge clk);
    check("midrst_req",     o_cmt_writebacked_req, 1'b0);
    check("midrst_instret", o_instret,             64'd0);
    check("midrst_timeout", o_wdog_timeout,        1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
